// File: rtl/mux_nto1_rr_reg_pkg.sv
// Shared definitions for the registered N-to-1 multiplexer.
//   mux_mode_e : selection mode carried on the top-level 'mode' port
//   wrap_inc   : index increment modulo n, used for the round-robin pointer
package mux_nto1_rr_reg_pkg;

    typedef enum logic {
        MUX_MODE_FIXED = 1'b0,
        MUX_MODE_RR    = 1'b1
    } mux_mode_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_nto1_rr_reg_arb.sv
// Combinational round-robin arbiter.
//   req       in   N     request vector
//   ptr       in   SELW  highest-priority index for this evaluation
//   gnt_idx   out  SELW  granted index (0 when gnt_valid=0)
//   gnt_valid out  1     at least one request present
module rr_arb_n #(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_valid
);
    import mux_nto1_rr_reg_pkg::*;

    logic [N-1:0]   mask;
    logic [2*N-1:0] scan;

    // Lower half keeps only requests at or above ptr; upper half holds all
    // requests, so the first set bit of the doubled vector is the first
    // requester at or after ptr with wraparound.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (i >= 32'(ptr));
        end
        scan      = {req, req & mask};
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned j = 0; j < 2 * N; j++) begin
            if (!gnt_valid && scan[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = (j >= N) ? SELW'(j - N) : SELW'(j);
            end
        end
    end

endmodule

// File: rtl/mux_nto1_rr_reg.sv
// N-channel, W-bit registered multiplexer with valid/ready on every input and
// on the output. Fixed mode takes channel 'sel'; round-robin mode scans from
// rr_ptr for the first valid channel.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      N*W   channel i data at [i*W +: W]
//   in_valid     N     channel i offers data
//   in_ready     N     channel i accepted this cycle (one-hot or zero)
//   mode         1     0 = fixed select, 1 = round-robin
//   sel          SELW  channel used in fixed mode
//   out_data     W     registered selected data
//   out_ch       SELW  channel that supplied out_data
//   out_valid    1     output slot holds a word
//   out_ready    1     downstream accepts the word
module mux_nto1_rr_reg #(
    parameter  int W    = 8,
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);
    import mux_nto1_rr_reg_pkg::*;

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q,   out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] rr_ptr_q,   rr_ptr_d;

    logic [SELW-1:0] rr_idx;
    logic            rr_valid;
    logic            fix_valid;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic            load_en;
    logic            accept;
    logic [W-1:0]    grant_data;

    rr_arb_n #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    always_comb begin
        load_en = !out_valid_q || out_ready;

        // Matching sel against every legal index means sel>=N simply finds
        // no channel, without an out-of-range bit select.
        fix_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                fix_valid = in_valid[i];
            end
        end

        if (mux_mode_e'(mode) == MUX_MODE_RR) begin
            grant       = rr_idx;
            grant_valid = rr_valid;
        end else begin
            grant       = sel;
            grant_valid = fix_valid;
        end

        accept = load_en && grant_valid;

        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    // Ready is additionally held low while reset is asserted so no producer
    // sees an accept that the held-in-reset registers would drop.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = rst_n && accept && (grant == SELW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_data_d  = grant_data;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (mux_mode_e'(mode) == MUX_MODE_RR) begin
                rr_ptr_d = SELW'(wrap_inc(32'(grant), N));
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Self-checking bench for mux_nto1_rr_reg (W=8, N=4).
module tb_mux_nto1_rr_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] chan_val [4];

    // Reference model state: one output slot plus the round-robin pointer.
    logic       m_vld = 1'b0;
    logic [7:0] m_data = '0;
    int         m_ch = 0;
    int         m_ptr = 0;
    logic       nx_vld = 1'b0;
    logic [7:0] nx_data = '0;
    int         nx_ch = 0;
    int         nx_ptr = 0;

    mux_nto1_rr_reg #(.W(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then compute the model's next state.
    always @(negedge clk) begin
        logic load, ok;
        int   g;
        logic [3:0] exp_rdy;
        if (!rst_n) begin
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_out_data", {24'b0, out_data}, 32'd0);
            chk("rst_out_ch", {30'b0, out_ch}, 32'd0);
            chk("rst_in_ready", {28'b0, in_ready}, 32'd0);
            nx_vld  = 1'b0;
            nx_data = '0;
            nx_ch   = 0;
            nx_ptr  = 0;
        end else begin
            load = !m_vld || out_ready;
            ok   = 1'b0;
            g    = 0;
            if (mode == 1'b0) begin
                g  = int'(sel);
                ok = (g < 4) && in_valid[g];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!ok && in_valid[(m_ptr + k) % 4]) begin
                        ok = 1'b1;
                        g  = (m_ptr + k) % 4;
                    end
                end
            end
            exp_rdy = (load && ok) ? 4'(1 << g) : 4'b0000;
            chk("mdl_out_valid", {31'b0, out_valid}, {31'b0, m_vld});
            chk("mdl_out_data", {24'b0, out_data}, {24'b0, m_data});
            chk("mdl_out_ch", {30'b0, out_ch}, 32'(m_ch));
            chk("mdl_in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
            nx_vld  = m_vld;
            nx_data = m_data;
            nx_ch   = m_ch;
            nx_ptr  = m_ptr;
            if (load) begin
                if (ok) begin
                    nx_vld  = 1'b1;
                    nx_data = chan_val[g];
                    nx_ch   = g;
                    if (mode) nx_ptr = (g + 1) % 4;
                end else begin
                    nx_vld = 1'b0;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_data <= '0;
            m_ch   <= 0;
            m_ptr  <= 0;
        end else begin
            m_vld  <= nx_vld;
            m_data <= nx_data;
            m_ch   <= nx_ch;
            m_ptr  <= nx_ptr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        chan_val[0] = 8'hAA;
        chan_val[1] = 8'h55;
        chan_val[2] = 8'hF0;
        chan_val[3] = 8'h0F;
        in_data = {8'h0F, 8'hF0, 8'h55, 8'hAA};

        tick();
        tick();
        rst_n = 1'b1;

        // Fixed mode, sel stepping 0..3.
        mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("fix_in_ready", {28'b0, in_ready}, 32'(1 << s));
            tick();
            chk("fix_out_data", {24'b0, out_data}, {24'b0, chan_val[s]});
            chk("fix_out_ch", {30'b0, out_ch}, 32'(s));
            chk("fix_out_valid", {31'b0, out_valid}, 32'd1);
        end

        // Round-robin, all valid: pointer still 0 after fixed accepts.
        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_in_ready", {28'b0, in_ready}, 32'(1 << (k % 4)));
            tick();
            chk("rr_out_ch", {30'b0, out_ch}, 32'(k % 4));
            chk("rr_out_data", {24'b0, out_data}, {24'b0, chan_val[k % 4]});
        end

        // Reset mid-run while a word is held.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'b0, out_data}, 32'd0);
        chk("mid_rst_ch", {30'b0, out_ch}, 32'd0);
        chk("mid_rst_ready", {28'b0, in_ready}, 32'd0);
        tick();
        chk("mid_rst_ready_held", {28'b0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // Sparse requests 1010 from pointer 0.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sparse_in_ready", {28'b0, in_ready}, (k % 2 == 0) ? 32'h2 : 32'h8);
            tick();
            chk("sparse_out_ch", {30'b0, out_ch}, (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Stall: word ch3/0F held three cycles, then drain and refill.
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", {28'b0, in_ready}, 32'd0);
            tick();
            chk("stall_out_data", {24'b0, out_data}, 32'h0F);
            chk("stall_out_ch", {30'b0, out_ch}, 32'd3);
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("refill_in_ready", {28'b0, in_ready}, 32'h1);
        tick();
        chk("refill_out_ch", {30'b0, out_ch}, 32'd0);
        chk("refill_out_data", {24'b0, out_data}, 32'hAA);

        // Fixed select of an idle channel: slot drains, data/ch held.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
        #1;
        chk("idle_in_ready", {28'b0, in_ready}, 32'd0);
        tick();
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_out_data", {24'b0, out_data}, 32'hAA);
        chk("idle_out_ch", {30'b0, out_ch}, 32'd0);
        mode = 1'b1;
        #1;
        chk("resume_in_ready", {28'b0, in_ready}, 32'h2);
        tick();
        chk("resume_out_ch", {30'b0, out_ch}, 32'd1);
        chk("resume_out_data", {24'b0, out_data}, 32'h55);
        // Fixed accept of ch0 must leave the pointer at 2, so RR then picks ch3.
        mode = 1'b0; sel = 2'd0;
        #1;
        chk("fixptr_in_ready", {28'b0, in_ready}, 32'h1);
        tick();
        chk("fixptr_out_ch", {30'b0, out_ch}, 32'd0);
        mode = 1'b1;
        #1;
        chk("ptr_kept_in_ready", {28'b0, in_ready}, 32'h8);
        tick();
        chk("ptr_kept_out_ch", {30'b0, out_ch}, 32'd3);
        chk("ptr_kept_out_data", {24'b0, out_data}, 32'h0F);

        // Mixed traffic, checked by the per-cycle model only.
        for (int k = 0; k < 200; k++) begin
            in_valid  = 4'($urandom_range(0, 15));
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
